pipe_stage_reg: RTL and testbench

//  Parametrised pipeline-stage register; successor to the fixed-field stall-only stage registers.

---
 rtl/pipe_stage_reg_pkg.sv | 67 ++++++
 rtl/pipe_stage_reg_if.sv | 32 +++
 rtl/pipe_stage_reg_slot.sv | 39 +++
 rtl/pipe_stage_reg.sv | 182 ++++++++++++++++++
 tb/tb_pipe_stage_reg.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/pipe_stage_reg_pkg.sv
// Shared pipeline-stage definitions: payload widths, ctrl/data field offsets, FSM encoding.
package pipe_stage_reg_pkg;

  // Default per-stage payload widths
  localparam int unsigned STAGE_CTRL_WIDTH = 10;
  localparam int unsigned STAGE_DATA_WIDTH = 284;
  localparam int unsigned OCC_WIDTH        = 2;

  // Ctrl word bit offsets (one bit per field)
  localparam int unsigned CTRL_REG_WRITE  = 0;
  localparam int unsigned CTRL_MEM_WRITE  = 1;
  localparam int unsigned CTRL_MEM_READ   = 2;
  localparam int unsigned CTRL_MEM_TO_REG = 3;
  localparam int unsigned CTRL_JUMP_SRC   = 4;
  localparam int unsigned CTRL_JALR_SRC   = 5;
  localparam int unsigned CTRL_U_SRC      = 6;
  localparam int unsigned CTRL_UJ_SRC     = 7;
  localparam int unsigned CTRL_ALU_SRC    = 8;
  localparam int unsigned CTRL_ALU_FPU    = 9;

  // Ctrl word as a packed struct; MSB first so reg_write lands on bit 0
  typedef struct packed {
    logic alu_fpu;
    logic alu_src;
    logic uj_src;
    logic u_src;
    logic jalr_src;
    logic jump_src;
    logic mem_to_reg;
    logic mem_read;
    logic mem_write;
    logic reg_write;
  } ctrl_t;

  // Data word field widths
  localparam int unsigned XLEN_W    = 64;
  localparam int unsigned REG_IDX_W = 5;
  localparam int unsigned FUNCT3_W  = 3;
  localparam int unsigned FUNCT7_W  = 7;
  localparam int unsigned RSVD_W    = 3;

  // Data word field offsets (LSB of each field)
  localparam int unsigned DATA_PC_LSB     = 0;
  localparam int unsigned DATA_OP_A_LSB   = DATA_PC_LSB + XLEN_W;
  localparam int unsigned DATA_OP_B_LSB   = DATA_OP_A_LSB + XLEN_W;
  localparam int unsigned DATA_IMM_LSB    = DATA_OP_B_LSB + XLEN_W;
  localparam int unsigned DATA_RS1_LSB    = DATA_IMM_LSB + XLEN_W;
  localparam int unsigned DATA_RS2_LSB    = DATA_RS1_LSB + REG_IDX_W;
  localparam int unsigned DATA_RD_LSB     = DATA_RS2_LSB + REG_IDX_W;
  localparam int unsigned DATA_FUNCT3_LSB = DATA_RD_LSB + REG_IDX_W;
  localparam int unsigned DATA_FUNCT7_LSB = DATA_FUNCT3_LSB + FUNCT3_W;
  localparam int unsigned DATA_RSVD_LSB   = DATA_FUNCT7_LSB + FUNCT7_W;
  localparam int unsigned DATA_END        = DATA_RSVD_LSB + RSVD_W;

  // Stage FSM; the encoding doubles as the live-entry count
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_e;

  // Occupancy reported for a given state
  function automatic logic [OCC_WIDTH-1:0] state_occ(input state_e s);
    return OCC_WIDTH'(s);
  endfunction

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Stage handshake bundle: upstream valid/ready/payload, downstream valid/ready/payload, flush, occupancy.
interface pipe_stage_reg_if
  import pipe_stage_reg_pkg::*;
#(
  parameter int unsigned CTRL_WIDTH = STAGE_CTRL_WIDTH,
  parameter int unsigned DATA_WIDTH = STAGE_DATA_WIDTH
);

  logic                  flush;
  logic                  in_valid;
  logic                  in_ready;
  logic [CTRL_WIDTH-1:0] in_ctrl;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [CTRL_WIDTH-1:0] out_ctrl;
  logic [DATA_WIDTH-1:0] out_data;
  logic [OCC_WIDTH-1:0]  occupancy;

  // Surrounding pipeline: feeds the stage and consumes its output
  modport master (
    output flush, in_valid, in_ctrl, in_data, out_ready,
    input  in_ready, out_valid, out_ctrl, out_data, occupancy
  );

  // The stage register itself
  modport slave (
    input  flush, in_valid, in_ctrl, in_data, out_ready,
    output in_ready, out_valid, out_ctrl, out_data, occupancy
  );

endinterface

// File: rtl/pipe_stage_reg_slot.sv
// Single payload slot: valid + ctrl + data with load and kill; ctrl is zeroed whenever the slot empties.
module pipe_slot
  import pipe_stage_reg_pkg::*;
#(
  parameter int unsigned CTRL_WIDTH = STAGE_CTRL_WIDTH,
  parameter int unsigned DATA_WIDTH = STAGE_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  clear,
  input  logic                  clear_data,
  input  logic [CTRL_WIDTH-1:0] ld_ctrl,
  input  logic [DATA_WIDTH-1:0] ld_data,
  output logic                  valid,
  output logic [CTRL_WIDTH-1:0] ctrl,
  output logic [DATA_WIDTH-1:0] data
);

  // Slot storage; clear wins over load so a kill can never be overwritten
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      ctrl  <= '0;
      data  <= '0;
    end else if (clear) begin
      valid <= 1'b0;
      ctrl  <= '0;
      if (clear_data) begin
        data <= '0;
      end
    end else if (load) begin
      valid <= 1'b1;
      ctrl  <= ld_ctrl;
      data  <= ld_data;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register: valid/ready handshake, sync flush, optional 2-entry skid with registered in_ready.
module pipe_stage_reg
  import pipe_stage_reg_pkg::*;
#(
  parameter int unsigned CTRL_WIDTH = STAGE_CTRL_WIDTH,
  parameter int unsigned DATA_WIDTH = STAGE_DATA_WIDTH,
  parameter bit          SKID       = 1'b1,
  parameter bit          FLUSH_DATA = 1'b0
) (
  input logic             clk,
  input logic             rst,
  pipe_stage_reg_if.slave bus
);

  state_e                state_q;
  state_e                state_d;

  logic                  in_ready_int;
  logic                  fire_in;
  logic                  fire_out;

  logic                  m_load;
  logic                  m_from_s;
  logic                  m_clear;
  logic                  clr_data;
  logic [CTRL_WIDTH-1:0] m_ld_ctrl;
  logic [DATA_WIDTH-1:0] m_ld_data;

  logic                  m_valid;
  logic [CTRL_WIDTH-1:0] m_ctrl;
  logic [DATA_WIDTH-1:0] m_data;

  logic                  s_valid;
  logic [CTRL_WIDTH-1:0] s_ctrl;
  logic [DATA_WIDTH-1:0] s_data;

  // Handshake qualifiers; flush drops any offered input
  assign fire_out = m_valid & bus.out_ready;
  assign fire_in  = bus.in_valid & in_ready_int & ~bus.flush;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (bus.flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (fire_in) begin
            state_d = ST_ONE;
          end
        end
        ST_ONE: begin
          if (fire_in && !fire_out) begin
            state_d = SKID ? ST_TWO : ST_ONE;
          end else if (!fire_in && fire_out) begin
            state_d = ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (fire_out) begin
            state_d = ST_ONE;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  // Main-slot control: load from input or from the skid slot, or kill
  always_comb begin
    m_load   = 1'b0;
    m_from_s = 1'b0;
    m_clear  = 1'b0;
    clr_data = 1'b0;
    if (bus.flush) begin
      m_clear  = 1'b1;
      clr_data = FLUSH_DATA;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          m_load = fire_in;
        end
        ST_ONE: begin
          if (fire_in && fire_out) begin
            m_load = 1'b1;
          end else if (fire_out) begin
            m_clear = 1'b1;
          end
        end
        ST_TWO: begin
          if (fire_out) begin
            m_load   = s_valid;
            m_from_s = 1'b1;
            m_clear  = ~s_valid;
          end
        end
        default: m_clear = 1'b1;
      endcase
    end
  end

  // Main-slot load source: skid slot drains first to keep FIFO order
  assign m_ld_ctrl = m_from_s ? s_ctrl : bus.in_ctrl;
  assign m_ld_data = m_from_s ? s_data : bus.in_data;

  pipe_slot #(
    .CTRL_WIDTH (CTRL_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_m (
    .clk        (clk),
    .rst        (rst),
    .load       (m_load),
    .clear      (m_clear),
    .clear_data (clr_data),
    .ld_ctrl    (m_ld_ctrl),
    .ld_data    (m_ld_data),
    .valid      (m_valid),
    .ctrl       (m_ctrl),
    .data       (m_data)
  );

  if (SKID) begin : g_skid
    logic s_load;
    logic s_clear;
    logic in_ready_q;

    // Skid slot catches the input that arrives while M is stalled
    assign s_load  = (state_q == ST_ONE) & fire_in & ~fire_out;
    assign s_clear = bus.flush | ((state_q == ST_TWO) & fire_out);

    pipe_slot #(
      .CTRL_WIDTH (CTRL_WIDTH),
      .DATA_WIDTH (DATA_WIDTH)
    ) u_s (
      .clk        (clk),
      .rst        (rst),
      .load       (s_load),
      .clear      (s_clear),
      .clear_data (clr_data),
      .ld_ctrl    (bus.in_ctrl),
      .ld_data    (bus.in_data),
      .valid      (s_valid),
      .ctrl       (s_ctrl),
      .data       (s_data)
    );

    // Registered ready: accept unless the stage will be full next cycle
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        in_ready_q <= 1'b1;
      end else begin
        in_ready_q <= (state_d != ST_TWO);
      end
    end

    assign in_ready_int = in_ready_q;
  end else begin : g_noskid
    assign s_valid      = 1'b0;
    assign s_ctrl       = '0;
    assign s_data       = '0;
    // Combinational ready: free, or the held entry leaves this cycle
    assign in_ready_int = ~m_valid | bus.out_ready;
  end

  // Outputs; ctrl is masked so a bubble can never carry write enables
  assign bus.in_ready  = in_ready_int;
  assign bus.out_valid = m_valid;
  assign bus.out_ctrl  = m_valid ? m_ctrl : '0;
  assign bus.out_data  = m_data;
  assign bus.occupancy = state_occ(state_q);

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: SKID=1 (a), SKID=0 (b), SKID=1 with FLUSH_DATA=1 (c).
module tb_pipe_stage_reg;
  import pipe_stage_reg_pkg::*;

  localparam int unsigned CW = STAGE_CTRL_WIDTH;
  localparam int unsigned DW = STAGE_DATA_WIDTH;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  pipe_stage_reg_if #(.CTRL_WIDTH(CW), .DATA_WIDTH(DW)) bus_a ();
  pipe_stage_reg_if #(.CTRL_WIDTH(CW), .DATA_WIDTH(DW)) bus_b ();
  pipe_stage_reg_if #(.CTRL_WIDTH(CW), .DATA_WIDTH(DW)) bus_c ();

  pipe_stage_reg #(.CTRL_WIDTH(CW), .DATA_WIDTH(DW), .SKID(1'b1), .FLUSH_DATA(1'b0))
    u_a (.clk(clk), .rst(rst), .bus(bus_a.slave));
  pipe_stage_reg #(.CTRL_WIDTH(CW), .DATA_WIDTH(DW), .SKID(1'b0), .FLUSH_DATA(1'b0))
    u_b (.clk(clk), .rst(rst), .bus(bus_b.slave));
  pipe_stage_reg #(.CTRL_WIDTH(CW), .DATA_WIDTH(DW), .SKID(1'b1), .FLUSH_DATA(1'b1))
    u_c (.clk(clk), .rst(rst), .bus(bus_c.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    bus_a.flush = 1'b0; bus_a.in_valid = 1'b0; bus_a.in_ctrl = '0; bus_a.in_data = '0; bus_a.out_ready = 1'b0;
    bus_b.flush = 1'b0; bus_b.in_valid = 1'b0; bus_b.in_ctrl = '0; bus_b.in_data = '0; bus_b.out_ready = 1'b0;
    bus_c.flush = 1'b0; bus_c.in_valid = 1'b0; bus_c.in_ctrl = '0; bus_c.in_data = '0; bus_c.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_all();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (bus_a.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", bus_a.out_valid); end
    checks++; if (bus_a.out_ctrl !== CW'(0)) begin errors++; $display("FAIL reset_out_ctrl got %h exp 0", bus_a.out_ctrl); end
    checks++; if (bus_a.out_data !== DW'(0)) begin errors++; $display("FAIL reset_out_data got %h exp 0", bus_a.out_data); end
    checks++; if (bus_a.occupancy !== 2'd0) begin errors++; $display("FAIL reset_occ got %0d exp 0", bus_a.occupancy); end
    checks++; if (bus_a.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready_a got %b exp 1", bus_a.in_ready); end
    checks++; if (bus_b.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready_b got %b exp 1", bus_b.in_ready); end
    step();
  endtask

  task automatic test_streaming();
    idle_all();
    bus_a.out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      bus_a.in_valid = 1'b1;
      bus_a.in_data  = DW'(i);
      bus_a.in_ctrl  = CW'(i);
      step();
      checks++; if (bus_a.out_valid !== 1'b1) begin errors++; $display("FAIL stream_valid[%0d] got %b exp 1", i, bus_a.out_valid); end
      checks++; if (bus_a.out_data !== DW'(i)) begin errors++; $display("FAIL stream_data[%0d] got %h exp %h", i, bus_a.out_data, DW'(i)); end
      checks++; if (bus_a.out_ctrl !== CW'(i)) begin errors++; $display("FAIL stream_ctrl[%0d] got %h exp %h", i, bus_a.out_ctrl, CW'(i)); end
      checks++; if (bus_a.in_ready !== 1'b1) begin errors++; $display("FAIL stream_in_ready[%0d] got %b exp 1", i, bus_a.in_ready); end
    end
    bus_a.in_valid = 1'b0;
    step();
    checks++; if (bus_a.out_valid !== 1'b0) begin errors++; $display("FAIL stream_drain_valid got %b exp 0", bus_a.out_valid); end
    checks++; if (bus_a.out_ctrl !== CW'(0)) begin errors++; $display("FAIL stream_drain_ctrl got %h exp 0", bus_a.out_ctrl); end
    checks++; if (bus_a.occupancy !== 2'd0) begin errors++; $display("FAIL stream_drain_occ got %0d exp 0", bus_a.occupancy); end
  endtask

  task automatic test_backpressure();
    idle_all();
    bus_a.in_valid = 1'b1; bus_a.in_data = DW'(32'hA); bus_a.in_ctrl = CW'(10'h00A);
    step();
    checks++; if (bus_a.occupancy !== 2'd1) begin errors++; $display("FAIL bp_occ1 got %0d exp 1", bus_a.occupancy); end
    bus_a.in_data = DW'(32'hB); bus_a.in_ctrl = CW'(10'h00B);
    step();
    checks++; if (bus_a.occupancy !== 2'd2) begin errors++; $display("FAIL bp_occ2 got %0d exp 2", bus_a.occupancy); end
    checks++; if (bus_a.in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready_full got %b exp 0", bus_a.in_ready); end
    bus_a.in_data = DW'(32'hC); bus_a.in_ctrl = CW'(10'h00C);
    step();
    checks++; if (bus_a.occupancy !== 2'd2) begin errors++; $display("FAIL bp_occ_hold got %0d exp 2", bus_a.occupancy); end
    checks++; if (bus_a.out_data !== DW'(32'hA)) begin errors++; $display("FAIL bp_hold_data got %h exp a", bus_a.out_data); end
    checks++; if (bus_a.in_ready !== 1'b0) begin errors++; $display("FAIL bp_c_held got %b exp 0", bus_a.in_ready); end
    bus_a.out_ready = 1'b1;
    #1;
    checks++; if (bus_a.out_data !== DW'(32'hA)) begin errors++; $display("FAIL bp_first_out got %h exp a", bus_a.out_data); end
    step();
    checks++; if (bus_a.out_data !== DW'(32'hB)) begin errors++; $display("FAIL bp_second_out got %h exp b", bus_a.out_data); end
    checks++; if (bus_a.occupancy !== 2'd1) begin errors++; $display("FAIL bp_occ_after_drain got %0d exp 1", bus_a.occupancy); end
    checks++; if (bus_a.in_ready !== 1'b1) begin errors++; $display("FAIL bp_in_ready_reopen got %b exp 1", bus_a.in_ready); end
    step();
    checks++; if (bus_a.out_data !== DW'(32'hC)) begin errors++; $display("FAIL bp_third_out got %h exp c", bus_a.out_data); end
    checks++; if (bus_a.out_ctrl !== CW'(10'h00C)) begin errors++; $display("FAIL bp_third_ctrl got %h exp 00c", bus_a.out_ctrl); end
    bus_a.in_valid = 1'b0;
    step();
    checks++; if (bus_a.out_valid !== 1'b0) begin errors++; $display("FAIL bp_empty got %b exp 0", bus_a.out_valid); end
  endtask

  task automatic test_flush_simultaneous();
    idle_all();
    bus_a.in_valid = 1'b1; bus_a.in_ctrl = CW'(10'h155); bus_a.in_data = DW'(32'h1);
    step();
    bus_a.in_ctrl = CW'(10'h2AA); bus_a.in_data = DW'(32'h2);
    step();
    checks++; if (bus_a.occupancy !== 2'd2) begin errors++; $display("FAIL flush_pre_occ got %0d exp 2", bus_a.occupancy); end
    bus_a.flush = 1'b1; bus_a.in_ctrl = CW'(10'h3FF); bus_a.in_data = DW'(32'h77);
    step();
    checks++; if (bus_a.out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid got %b exp 0", bus_a.out_valid); end
    checks++; if (bus_a.out_ctrl !== CW'(0)) begin errors++; $display("FAIL flush_ctrl got %h exp 0", bus_a.out_ctrl); end
    checks++; if (bus_a.occupancy !== 2'd0) begin errors++; $display("FAIL flush_occ got %0d exp 0", bus_a.occupancy); end
    checks++; if (bus_a.in_ready !== 1'b1) begin errors++; $display("FAIL flush_in_ready got %b exp 1", bus_a.in_ready); end
    // Flush from EMPTY with in_ready=1: the offered input must still be dropped
    step();
    bus_a.flush = 1'b0; bus_a.in_valid = 1'b0; bus_a.out_ready = 1'b1;
    step();
    checks++; if (bus_a.out_valid !== 1'b0) begin errors++; $display("FAIL flush_dropped_input got %b exp 0", bus_a.out_valid); end
    checks++; if (bus_a.occupancy !== 2'd0) begin errors++; $display("FAIL flush_dropped_occ got %0d exp 0", bus_a.occupancy); end
  endtask

  task automatic test_skid0();
    idle_all();
    bus_b.out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      bus_b.in_valid = 1'b1;
      bus_b.in_data  = DW'(32'h40 + i);
      bus_b.in_ctrl  = CW'(i);
      #1;
      checks++; if (bus_b.in_ready !== 1'b1) begin errors++; $display("FAIL s0_in_ready[%0d] got %b exp 1", i, bus_b.in_ready); end
      step();
      checks++; if (bus_b.out_data !== DW'(32'h40 + i)) begin errors++; $display("FAIL s0_data[%0d] got %h exp %h", i, bus_b.out_data, DW'(32'h40 + i)); end
      checks++; if (bus_b.occupancy !== 2'd1) begin errors++; $display("FAIL s0_occ[%0d] got %0d exp 1", i, bus_b.occupancy); end
    end
    bus_b.out_ready = 1'b0; bus_b.in_data = DW'(32'h50); bus_b.in_ctrl = CW'(5);
    #1;
    checks++; if (bus_b.in_ready !== 1'b0) begin errors++; $display("FAIL s0_in_ready_comb got %b exp 0", bus_b.in_ready); end
    step();
    checks++; if (bus_b.out_data !== DW'(32'h44)) begin errors++; $display("FAIL s0_hold_data got %h exp 44", bus_b.out_data); end
    checks++; if (bus_b.occupancy !== 2'd1) begin errors++; $display("FAIL s0_hold_occ got %0d exp 1", bus_b.occupancy); end
    bus_b.out_ready = 1'b1;
    #1;
    checks++; if (bus_b.in_ready !== 1'b1) begin errors++; $display("FAIL s0_in_ready_reopen got %b exp 1", bus_b.in_ready); end
    step();
    checks++; if (bus_b.out_data !== DW'(32'h50)) begin errors++; $display("FAIL s0_resume_data got %h exp 50", bus_b.out_data); end
    bus_b.in_valid = 1'b0;
    step();
    checks++; if (bus_b.out_valid !== 1'b0) begin errors++; $display("FAIL s0_empty got %b exp 0", bus_b.out_valid); end
  endtask

  task automatic test_flush_data();
    idle_all();
    bus_a.in_valid = 1'b1; bus_a.in_data = DW'(32'hDEAD); bus_a.in_ctrl = CW'(10'h003);
    bus_c.in_valid = 1'b1; bus_c.in_data = DW'(32'hDEAD); bus_c.in_ctrl = CW'(10'h003);
    step();
    checks++; if (bus_c.out_data !== DW'(32'hDEAD)) begin errors++; $display("FAIL fd_c_loaded got %h exp dead", bus_c.out_data); end
    bus_a.in_valid = 1'b0; bus_a.flush = 1'b1;
    bus_c.in_valid = 1'b0; bus_c.flush = 1'b1;
    step();
    checks++; if (bus_c.out_data !== DW'(0)) begin errors++; $display("FAIL fd_c_zeroed got %h exp 0", bus_c.out_data); end
    checks++; if (bus_c.out_valid !== 1'b0) begin errors++; $display("FAIL fd_c_valid got %b exp 0", bus_c.out_valid); end
    checks++; if (bus_a.out_data !== DW'(32'hDEAD)) begin errors++; $display("FAIL fd_a_kept got %h exp dead", bus_a.out_data); end
    checks++; if (bus_a.out_valid !== 1'b0) begin errors++; $display("FAIL fd_a_valid got %b exp 0", bus_a.out_valid); end
    bus_a.flush = 1'b0; bus_c.flush = 1'b0;
    step();
    checks++; if (bus_a.out_data !== DW'(32'hDEAD)) begin errors++; $display("FAIL fd_a_still_kept got %h exp dead", bus_a.out_data); end
    checks++; if (bus_a.out_ctrl !== CW'(0)) begin errors++; $display("FAIL fd_a_ctrl got %h exp 0", bus_a.out_ctrl); end
  endtask

  task automatic test_reset_mid();
    idle_all();
    bus_a.in_valid = 1'b1; bus_a.in_data = DW'(32'h11); bus_a.in_ctrl = CW'(10'h011);
    step();
    bus_a.in_data = DW'(32'h22); bus_a.in_ctrl = CW'(10'h022);
    step();
    checks++; if (bus_a.occupancy !== 2'd2) begin errors++; $display("FAIL rmid_pre_occ got %0d exp 2", bus_a.occupancy); end
    #2;
    rst = 1'b1;
    #1;
    checks++; if (bus_a.out_valid !== 1'b0) begin errors++; $display("FAIL rmid_async_valid got %b exp 0", bus_a.out_valid); end
    checks++; if (bus_a.occupancy !== 2'd0) begin errors++; $display("FAIL rmid_async_occ got %0d exp 0", bus_a.occupancy); end
    idle_all();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (bus_a.in_ready !== 1'b1) begin errors++; $display("FAIL rmid_in_ready got %b exp 1", bus_a.in_ready); end
    bus_a.in_valid = 1'b1; bus_a.in_data = DW'(32'h33); bus_a.in_ctrl = CW'(10'h033); bus_a.out_ready = 1'b1;
    step();
    checks++; if (bus_a.out_data !== DW'(32'h33)) begin errors++; $display("FAIL rmid_first_data got %h exp 33", bus_a.out_data); end
    checks++; if (bus_a.occupancy !== 2'd1) begin errors++; $display("FAIL rmid_first_occ got %0d exp 1", bus_a.occupancy); end
    bus_a.in_valid = 1'b0;
    step();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush_simultaneous();
    test_skid0();
    test_flush_data();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

endmodule
